// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-state encoding, default vectors and alignment mask
package pc_fetch_pkg;
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_t;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam logic [1:0]  ALIGN_MASK    = 2'b11;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry valid/ready register holding pc and instruction, with flush
module fetch_buffer
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_pc,
  input  logic [XLEN-1:0] fill_instr,
  input  logic            flush,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else begin
      valid <= !flush && (fill || (valid && !ready));
      if (fill) begin
        pc    <= fill_pc;
        instr <= fill_instr;
      end
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch front end
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              PC_STEP   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  input  logic            if_ready_i,
  output logic            misalign_o
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic [XLEN-1:0] misalign_addr_o
`endif
);
  fetch_state_t    state, state_n;
  logic            kill, kill_n;
  logic [XLEN-1:0] pc, pc_n, target;
  logic            redir, fill;
  assign redir = trap_i || redirect_valid_i;
`ifdef PC_MISALIGN_TRAP_EN
  logic bad;
  assign bad    = redirect_valid_i && !trap_i && |(redirect_pc_i[1:0] & ALIGN_MASK);
  assign target = (trap_i || bad) ? TRAP_VEC : redirect_pc_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= bad;
      if (bad) misalign_addr_o <= redirect_pc_i;
    end
  end
`else
  assign target     = trap_i ? TRAP_VEC : (redirect_pc_i & ~XLEN'(ALIGN_MASK));
  assign misalign_o = 1'b0;
`endif
  // a response is only accepted when it belongs to a live fetch and no redirect lands this cycle
  assign fill        = (state == WAIT) && imem_rvalid_i && !kill && !redir;
  assign pc_n        = redir ? target : fill ? pc + XLEN'(PC_STEP) : pc;
  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;
  always_comb begin
    state_n = state;
    kill_n  = kill;
    case (state)
      BOOT: state_n = REQ;
      REQ:
        if (imem_gnt_i) begin
          state_n = WAIT;
          kill_n  = redir;
        end
      WAIT:
        if (imem_rvalid_i) begin
          kill_n  = 1'b0;
          state_n = (redir || kill || if_ready_i) ? REQ : HOLD;
        end else begin
          kill_n = kill || redir;
        end
      HOLD: state_n = (redir || (if_ready_i && if_valid_o)) ? REQ : HOLD;
      default: state_n = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      kill  <= 1'b0;
      pc    <= RESET_VEC;
    end else begin
      state <= state_n;
      kill  <= kill_n;
      pc    <= pc_n;
    end
  end
  fetch_buffer #(.XLEN(XLEN)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill),
    .fill_pc    (pc),
    .fill_instr (imem_rdata_i),
    .flush      (redir),
    .ready      (if_ready_i),
    .valid      (if_valid_o),
    .pc         (if_pc_o),
    .instr      (if_instr_o)
  );
endmodule
